// File: rtl/bin2qdi_1of2_tx_if.sv
// Handshake bundle between the binary source, the sender and the QDI circuit.
// din/din_valid/din_ready face the source; R/Re face the dual-rail channel.
interface bin2qdi_1of2_tx_if;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic [1:0] R;
    logic       Re;

    modport master (
        input  din,
        input  din_valid,
        input  Re,
        output din_ready,
        output R
    );

    modport slave (
        output din,
        output din_valid,
        output Re,
        input  din_ready,
        input  R
    );
endinterface

// File: rtl/bin2qdi_1of2_tx.sv
// Binary-to-e1of2 four-phase sender: FIFO, Re synchroniser and a
// data/neutral sequencer with registered outputs.
module bin2qdi_1of2_tx #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    bin2qdi_1of2_tx_if.master          bus,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [CNT_W-1:0]           tok_cnt,
    output logic                       err,
    inout  wire                        VDD,
    inout  wire                        GND
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_NULL = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DEPTH-1:0]     mem_q;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        level_q, level_d;
    logic                 ready_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 re_s;
    logic                 re_s_prev_q;
    logic [1:0]           r_q, r_d;
    logic [CNT_W-1:0]     tok_q, tok_d;
    logic                 err_q, err_d;
    logic                 push, pop;
    logic                 head_avail;

    // Supply pins carry no logic; fold them into a sink.
    wire unused_supply = VDD ^ GND;

    assign re_s       = sync_q[SYNC_STAGES-1];
    assign push       = bus.din_valid & ready_q;
    assign pop        = (state_q == S_DATA) & ~re_s;
    assign head_avail = (level_q != '0) & re_s;

    assign bus.din_ready = ready_q;
    assign bus.R         = r_q;
    assign level         = level_q;
    assign tok_cnt       = tok_q;
    assign err           = err_q;

    // Bring the asynchronous enable into the CLK domain.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_q      <= '0;
            re_s_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.Re};
            re_s_prev_q <= re_s;
        end
    end

    // FIFO storage and pointers; pointers wrap on the power-of-two depth.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.din;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Occupancy follows push/pop; a simultaneous pair leaves it unchanged.
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Occupancy and the registered not-full flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            level_q <= '0;
            ready_q <= 1'b0;
        end else begin
            level_q <= level_d;
            ready_q <= (level_d != LW'(DEPTH));
        end
    end

    // Sequencer state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state: data on enable, neutral on acknowledge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (head_avail) state_d = S_DATA;
            S_DATA:  if (!re_s) state_d = S_NULL;
            S_NULL:  if (re_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next rail values, token count and sticky acknowledge-without-data flag.
    always_comb begin
        r_d   = r_q;
        tok_d = tok_q + CNT_W'(pop);
        err_d = err_q | (re_s_prev_q & ~re_s & (state_q != S_DATA));
        unique case (state_q)
            S_IDLE: begin
                if (head_avail) begin
                    r_d = mem_q[rd_ptr_q] ? 2'b10 : 2'b01;
                end else begin
                    r_d = 2'b00;
                end
            end
            S_DATA:  if (!re_s) r_d = 2'b00;
            S_NULL:  r_d = 2'b00;
            default: r_d = 2'b00;
        endcase
    end

    // Registered outputs towards the circuit and status.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_q   <= 2'b00;
            tok_q <= '0;
            err_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            tok_q <= tok_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_bin2qdi_1of2_tx.sv
// Self-checking bench for bin2qdi_1of2_tx: directed tables plus a randomized
// source/receiver pair against a queue-based token model.
module tb_bin2qdi_1of2_tx;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int CNT_W = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst_n;
    wire  vdd_w;
    wire  gnd_w;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] tok_cnt;
    logic             err;

    assign vdd_w = 1'b1;
    assign gnd_w = 1'b0;

    bin2qdi_1of2_tx_if bus();

    bin2qdi_1of2_tx #(
        .DEPTH(DEPTH),
        .SYNC_STAGES(SYNC),
        .CNT_W(CNT_W)
    ) dut (
        .CLK(clk),
        .RESET(rst_n),
        .bus(bus),
        .level(level),
        .tok_cnt(tok_cnt),
        .err(err),
        .VDD(vdd_w),
        .GND(gnd_w)
    );

    int checks   = 0;
    int failures = 0;
    int push_cnt = 0;
    int model_tok = 0;
    logic model_q[$];
    logic [1:0] prev_r = 2'b00;

    typedef struct {
        logic       din;
        logic [1:0] exp_r;
    } vec_t;
    vec_t vecs[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record accepted bits exactly when the source handshake completes.
    always @(posedge clk) begin
        if (rst_n && bus.din_valid && bus.din_ready) begin
            model_q.push_back(bus.din);
            push_cnt++;
        end
    end

    // Rails must never show 11 nor jump straight between the two codes.
    always @(negedge clk) begin
        checks++;
        if (bus.R == 2'b11 ||
            (prev_r != 2'b00 && bus.R != 2'b00 && bus.R != prev_r)) begin
            failures++;
            $display("FAIL r_legal: got %b after %b", bus.R, prev_r);
        end
        prev_r = bus.R;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.din_valid = 1'b0;
        bus.din = 1'b0;
        bus.Re = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_R", 32'(bus.R), 32'(0));
        check("rst_ready", 32'(bus.din_ready), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_tok", 32'(tok_cnt), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        model_q.delete();
        model_tok = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.din_ready), 32'(1));
        repeat (4) @(negedge clk);
    endtask

    task automatic push_bit(input logic b);
        int c0;
        int n;
        c0 = push_cnt;
        bus.din = b;
        bus.din_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (push_cnt == c0 && n < 400);
        check("push_accept", 32'(push_cnt != c0), 32'(1));
        bus.din_valid = 1'b0;
    endtask

    task automatic ack_token(input int rise_dly, output logic [1:0] seen);
        int n;
        logic [1:0] exp;
        n = 0;
        while (bus.R == 2'b00 && n < 300) begin
            @(negedge clk);
            n++;
        end
        seen = bus.R;
        check("data_wait", 32'(bus.R != 2'b00), 32'(1));
        if (bus.R == 2'b00) return;
        exp = (model_q.size() == 0) ? 2'b11 : (model_q[0] ? 2'b10 : 2'b01);
        check("r_code", 32'(bus.R), 32'(exp));
        bus.Re = 1'b0;
        n = 0;
        while (bus.R != 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ack_latency", 32'(n), 32'(SYNC + 1));
        if (model_q.size() != 0) void'(model_q.pop_front());
        model_tok++;
        check("tok_cnt", 32'(tok_cnt), 32'(model_tok % (1 << CNT_W)));
        repeat (rise_dly) @(negedge clk);
        bus.Re = 1'b1;
    endtask

    initial begin
        logic [1:0] seen;
        int c0;
        int n;
        logic ok;

        rst_n = 1'b0;
        bus.Re = 1'b1;
        bus.din = 1'b0;
        bus.din_valid = 1'b0;

        // Single token: latency in and out.
        do_reset();
        push_bit(1'b1);
        check("t1_level_after_push", 32'(level), 32'(1));
        check("t1_R_before", 32'(bus.R), 32'(0));
        @(negedge clk);
        check("t1_R_data", 32'(bus.R), 32'(2'b10));
        ack_token(0, seen);
        check("t1_level_after_pop", 32'(level), 32'(0));
        repeat (4) @(negedge clk);
        check("t1_R_idle", 32'(bus.R), 32'(0));
        check("t1_err", 32'(err), 32'(0));

        // Table of back-to-back bits with expected rail codes.
        vecs[0] = '{din: 1'b0, exp_r: 2'b01};
        vecs[1] = '{din: 1'b1, exp_r: 2'b10};
        vecs[2] = '{din: 1'b1, exp_r: 2'b10};
        vecs[3] = '{din: 1'b0, exp_r: 2'b01};
        do_reset();
        for (int i = 0; i < 4; i++) push_bit(vecs[i].din);
        for (int i = 0; i < 4; i++) begin
            ack_token(1, seen);
            check("t2_table_r", 32'(seen), 32'(vecs[i].exp_r));
        end
        check("t2_tok", 32'(tok_cnt), 32'(4));
        check("t2_err", 32'(err), 32'(0));

        // Fill without acknowledge; the fifth bit waits for the first pop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_bit(1'($urandom_range(0, 1)));
        check("t3_level_full", 32'(level), 32'(DEPTH));
        check("t3_ready_low", 32'(bus.din_ready), 32'(0));
        c0 = push_cnt;
        bus.din = 1'($urandom_range(0, 1));
        bus.din_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("t3_held", 32'(push_cnt), 32'(c0));
        check("t3_level_held", 32'(level), 32'(DEPTH));
        ack_token(1, seen);
        n = 0;
        while (push_cnt == c0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_fifth_accepted", 32'(push_cnt), 32'(c0 + 1));
        bus.din_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) ack_token(0, seen);
        check("t3_level_empty", 32'(level), 32'(0));

        // Randomized source and receiver running concurrently.
        do_reset();
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    push_bit(1'($urandom_range(0, 1)));
                end
            end
            begin
                logic [1:0] s;
                for (int j = 0; j < 30; j++) ack_token($urandom_range(0, 5), s);
            end
        join
        repeat (6) @(negedge clk);
        check("rnd_level", 32'(level), 32'(0));
        check("rnd_model_empty", 32'(model_q.size()), 32'(0));
        check("rnd_tok", 32'(tok_cnt), 32'(30 % (1 << CNT_W)));
        check("rnd_err", 32'(err), 32'(0));

        // Reset in the middle of a token.
        do_reset();
        push_bit(1'b1);
        n = 0;
        while (bus.R == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_R_data", 32'(bus.R), 32'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        check("t4_R_async", 32'(bus.R), 32'(0));
        check("t4_level", 32'(level), 32'(0));
        check("t4_tok", 32'(tok_cnt), 32'(0));
        check("t4_err", 32'(err), 32'(0));
        model_q.delete();
        model_tok = 0;
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.R != 2'b00) ok = 1'b0;
        end
        check("t4_no_stale", 32'(ok), 32'(1));
        check("t4_level_post", 32'(level), 32'(0));

        // Counter wrap over 2^CNT_W + 3 tokens.
        do_reset();
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            push_bit(1'($urandom_range(0, 1)));
            ack_token($urandom_range(0, 2), seen);
        end
        repeat (4) @(negedge clk);
        check("t6_tok_wrap", 32'(tok_cnt), 32'(3));

        // Acknowledge with no data pending sets a sticky error.
        check("t5_err_before", 32'(err), 32'(0));
        bus.Re = 1'b0;
        repeat (3) @(negedge clk);
        bus.Re = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_err_set", 32'(err), 32'(1));
        check("t5_R_null", 32'(bus.R), 32'(0));
        repeat (10) @(negedge clk);
        check("t5_err_sticky", 32'(err), 32'(1));
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin2qdi_1of2_tx.md
Name: bin2qdi_1of2_tx

Overview:
- Clocked sender that turns binary bits from verilog testbench/logic into a four-phase e1of2 dual-rail stream driving a QDI circuit.
- Direct upstream partner of the dual-rail-to-binary receiver stage: its R output and Re input connect to a QDI circuit whose far end feeds that receiver.
- Buffers bits in a small FIFO, synchronises the asynchronous enable, and sequences data/neutral phases with an FSM.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, flops in the Re synchroniser; minimum 2.
- CNT_W, 16, width of the delivered-token counter.

Ports:
- CLK  input  1  sole clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- din  input  1  binary bit to send.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  FIFO can accept; push = din_valid & din_ready at a CLK edge.
- R  output  2  dual-rail e1of2 data to circuit: 01 = 0, 10 = 1, 00 = neutral.
- Re  input  1  enable from circuit; asynchronous; high = ready for data, low = data acknowledged.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.
- tok_cnt  output  CNT_W  tokens completed (acknowledged), wraps modulo 2^CNT_W.
- err  output  1  sticky protocol-error flag.
- VDD, GND  inout  1  supply pins, no logic function.

Behaviour:
- Reset (RESET low, asynchronous): R=00, din_ready=0, level=0, tok_cnt=0, err=0, FIFO cleared, synchroniser flops=0, FSM=S_IDLE. Reset mid-token drops R to 00 immediately; the in-flight bit is discarded.
- din_ready is registered, = !full. It rises on the first CLK edge after RESET deasserts. No push when full, even when a pop occurs in the same cycle.
- Re_s is Re after SYNC_STAGES flops. The FSM uses only Re_s.
- FSM, all outputs registered:
  - S_IDLE: R=00. If level>0 and Re_s=1, drive R from the FIFO head (0 -> 01, 1 -> 10) and go to S_DATA.
  - S_DATA: hold R. When Re_s=0, set R=00, pop FIFO, increment tok_cnt, and go to S_NULL.
  - S_NULL: R=00. When Re_s=1, go to S_IDLE.
- R transitions only between 00 and one valid code. 11 is never driven. R never changes directly from one code to the other.
- Latency: a bit pushed at edge N into an empty FIFO with FSM in S_IDLE and Re_s=1 appears on R after edge N+1. A Re fall is reflected as R=00 SYNC_STAGES+1 edges later.
- Back-to-back throughput: one token per full Re handshake. The minimum token period is 2*(SYNC_STAGES+1) cycles plus the circuit's delay.
- Simultaneous push and pop: level is unchanged; pointers wrap modulo DEPTH.
- err is set (sticky until reset) when Re_s falls while FSM != S_DATA, meaning an acknowledge with no data driven.
- Empty FIFO: the FSM waits in S_IDLE with R=00 indefinitely.
- Re held high in S_DATA: R is held indefinitely and there is no timeout.

Test Plan:
- Release RESET with Re=1, push din=1 at edge 5 -> R=10 after edge 6. Drop Re -> R=00 after 3 edges, tok_cnt=1, level=0. Raise Re -> FSM returns to S_IDLE.
- Push 0,1,1,0 in consecutive cycles with the receiver model acking each token -> R sequence 01,00,10,00,10,00,01,00. tok_cnt=4, err=0.
- Hold Re=1 without ack and push 5 bits with DEPTH=4 -> din_ready=0 once level=4. The 5th bit is held by the source and accepted only after the first ack pop.
- Assert RESET while R=10 -> R=00 asynchronously. level, tok_cnt and err all 0. After release, no stale bit is emitted.
- Pulse Re low while in S_IDLE with the FIFO empty -> err=1 and stays 1 until the next reset. R remains 00.
- Run 2^CNT_W+3 tokens with CNT_W=4 (19 tokens) -> tok_cnt=3 at the end.
